// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: pipeline <-> multiply/divide unit bundle.
// Master is the pipeline side; slave is the MDU.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, src_a, src_b,
    output cancel, mthi, mtlo, wdata,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, src_a, src_b,
    input  cancel, mthi, mtlo, wdata,
    output busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// MDU_DIVZERO_FAST_EN: divide by zero finishes in one cycle.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  mdu_hilo_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    acc_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] a_raw_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             div_q;
  logic             neg_q;
  logic             rneg_q;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic             fast_dz;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Operand magnitudes and signs as seen at start
  always_comb begin
    sgn    = ~bus.op[0];
    a_neg  = sgn & bus.src_a[WIDTH-1];
    b_neg  = sgn & bus.src_b[WIDTH-1];
    b_zero = (bus.src_b == '0);
    a_mag  = a_neg ? -bus.src_a : bus.src_a;
    b_mag  = b_neg ? -bus.src_b : bus.src_b;
  end

`ifdef MDU_DIVZERO_FAST_EN
  assign fast_dz = bus.op[1] & b_zero;
`else
  assign fast_dz = 1'b0;
`endif

  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dup;
  logic [WIDTH:0]   ddif;
  logic [W2-1:0]    step;

  // One radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    msum = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, m_q};
    dup  = acc_q[W2-1:WIDTH-1];
    ddif = dup - {1'b0, m_q};
    if (div_q) begin
      if (ddif[WIDTH]) begin
        step = {acc_q[W2-2:0], 1'b0};
      end else begin
        step = {ddif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else if (acc_q[0]) begin
      step = {msum, acc_q[WIDTH-1:1]};
    end else begin
      step = {1'b0, acc_q[W2-1:1]};
    end
  end

  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Sign correction of the final step's value
  always_comb begin
    prod = neg_q ? -step : step;
    quo  = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem  = rneg_q ? -step[W2-1:WIDTH] : step[W2-1:WIDTH];
    if (dz_q) begin
      res_hi = a_raw_q;
      res_lo = '1;
    end else if (div_q) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[W2-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      a_raw_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.start) begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end else if (!bus.cancel) begin
            div_q   <= bus.op[1];
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            dz_q    <= bus.op[1] & b_zero;
            a_raw_q <= bus.src_a;
            busy_q  <= 1'b1;
            if (bus.op[1]) begin
              acc_q <= {{WIDTH{1'b0}}, a_mag};
              m_q   <= b_mag;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, b_mag};
              m_q   <= a_mag;
            end
            if (fast_dz) begin
              hi_q    <= bus.src_a;
              lo_q    <= '1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q   <= CW'(WIDTH);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.cancel) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= step;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
endmodule
